// File: rtl/armcpu_pkg.sv
// Shared definitions for the banked ARM register file: mode encodings, bank
// indices and the physical register layout. The layout depends on the
// REGFILE_FIQ_BANK_EN macro (FIQ-private r8-r12 present when defined).
package armcpu_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    typedef enum logic [2:0] {
        BANK_USR = 3'd0,
        BANK_FIQ = 3'd1,
        BANK_IRQ = 3'd2,
        BANK_SVC = 3'd3,
        BANK_ABT = 3'd4,
        BANK_UND = 3'd5
    } bank_e;

    // Physical layout: user r0-r14 first, then r13/r14 pairs per exception
    // mode, then the optional FIQ-private r8-r12 at the very end so they can
    // be dropped without renumbering anything else.
    localparam int PHYS_IDX_W = 5;
    localparam int NUM_USR    = 15;
    localparam int NUM_OTHER  = 8;
    localparam int NUM_SPSR   = 5;

    localparam logic [PHYS_IDX_W-1:0] PHYS_FIQ_R13 = 5'd15;
    localparam logic [PHYS_IDX_W-1:0] PHYS_IRQ_R13 = 5'd17;
    localparam logic [PHYS_IDX_W-1:0] PHYS_SVC_R13 = 5'd19;
    localparam logic [PHYS_IDX_W-1:0] PHYS_ABT_R13 = 5'd21;
    localparam logic [PHYS_IDX_W-1:0] PHYS_UND_R13 = 5'd23;
    localparam logic [PHYS_IDX_W-1:0] PHYS_FIQ_R8  = 5'd25;

`ifdef REGFILE_FIQ_BANK_EN
    localparam int NUM_FIQ  = 7;
    localparam int NUM_PHYS = 30;
`else
    localparam int NUM_FIQ  = 2;
    localparam int NUM_PHYS = 25;
`endif

    // Unknown encodings and SYS fall back to the user bank.
    function automatic bank_e mode_to_bank(input logic [4:0] mode);
        case (mode)
            MODE_FIQ: return BANK_FIQ;
            MODE_IRQ: return BANK_IRQ;
            MODE_SVC: return BANK_SVC;
            MODE_ABT: return BANK_ABT;
            MODE_UND: return BANK_UND;
            default:  return BANK_USR;
        endcase
    endfunction

endpackage

// File: rtl/regfile_bank_map.sv
// Combinational map from (processor mode, architectural register) to the
// physical storage index. r15 is flagged separately because it lives in
// the PC register, not in the array. FIQ r8-r12 banking follows
// REGFILE_FIQ_BANK_EN.
import armcpu_pkg::*;

module regfile_bank_map #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic [4:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [PHYS_IDX_W-1:0] phys_idx,
    output logic                  is_pc
);

    bank_e                 bank;
    logic [PHYS_IDX_W-1:0] hi;

    assign bank = mode_to_bank(mode);
    assign hi   = (addr == ADDR_WIDTH'(14)) ? PHYS_IDX_W'(1) : PHYS_IDX_W'(0);

    // Resolve the banked slot; unbanked registers map straight through.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        phys_idx = PHYS_IDX_W'(addr);
        is_pc    = (addr == ADDR_WIDTH'(15));
        if (addr == ADDR_WIDTH'(13) || addr == ADDR_WIDTH'(14)) begin
            case (bank)
                BANK_FIQ: phys_idx = PHYS_FIQ_R13 + hi;
                BANK_IRQ: phys_idx = PHYS_IRQ_R13 + hi;
                BANK_SVC: phys_idx = PHYS_SVC_R13 + hi;
                BANK_ABT: phys_idx = PHYS_ABT_R13 + hi;
                BANK_UND: phys_idx = PHYS_UND_R13 + hi;
                default:  phys_idx = PHYS_IDX_W'(addr);
            endcase
        end
`ifdef REGFILE_FIQ_BANK_EN
        if (bank == BANK_FIQ && addr >= ADDR_WIDTH'(8) && addr <= ADDR_WIDTH'(12)) begin
            phys_idx = PHYS_FIQ_R8 + PHYS_IDX_W'(addr - ADDR_WIDTH'(8));
        end
`endif
    end

endmodule

// File: rtl/arm_banked_regfile.sv
// ARM banked register file: N registered read ports, two write ports,
// per-mode banking of r13/r14 (and FIQ r8-r12 when REGFILE_FIQ_BANK_EN is
// defined), one SPSR per exception mode. The mode comes from the stored
// CPSR, so a CPSR write only affects accesses from the next cycle on.
import armcpu_pkg::*;

module arm_banked_regfile #(
    parameter int                  WORD_SIZE      = 32,
    parameter int                  ADDR_WIDTH     = 4,
    parameter int                  NUM_READ_PORTS = 3,
    parameter logic [WORD_SIZE-1:0] PC_RESET      = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ_PORTS*WORD_SIZE-1:0]  read_data,
    input  logic                                 wr0_we,
    input  logic [ADDR_WIDTH-1:0]                wr0_addr,
    input  logic [WORD_SIZE-1:0]                 wr0_data,
    input  logic                                 wr1_we,
    input  logic [ADDR_WIDTH-1:0]                wr1_addr,
    input  logic [WORD_SIZE-1:0]                 wr1_data,
    input  logic                                 pc_we,
    input  logic [WORD_SIZE-1:0]                 pc_in,
    output logic [WORD_SIZE-1:0]                 pc_out,
    input  logic                                 cpsr_we,
    input  logic [WORD_SIZE-1:0]                 cpsr_in,
    output logic [WORD_SIZE-1:0]                 cpsr_out,
    input  logic                                 spsr_we,
    input  logic [WORD_SIZE-1:0]                 spsr_in,
    output logic [WORD_SIZE-1:0]                 spsr_out
);

    logic [WORD_SIZE-1:0]  regs      [NUM_PHYS];
    logic [WORD_SIZE-1:0]  spsr_regs [NUM_SPSR];

    logic [4:0]            mode;
    bank_e                 bank;
    logic [2:0]            spsr_idx;

    logic [PHYS_IDX_W-1:0] w0_idx, w1_idx;
    logic                  w0_pc, w1_pc;
    logic                  w0_reg, w1_reg;
    logic [WORD_SIZE-1:0]  pc_next;
    logic [WORD_SIZE-1:0]  spsr_next;

    logic [PHYS_IDX_W-1:0] rd_idx  [NUM_READ_PORTS];
    logic                  rd_pc   [NUM_READ_PORTS];
    logic [WORD_SIZE-1:0]  rd_next [NUM_READ_PORTS];

    assign mode     = cpsr_out[4:0];
    assign bank     = mode_to_bank(mode);
    assign spsr_idx = 3'(bank) - 3'd1;

    regfile_bank_map #(.ADDR_WIDTH(ADDR_WIDTH)) u_map_wr0 (
        .mode(mode), .addr(wr0_addr), .phys_idx(w0_idx), .is_pc(w0_pc)
    );
    regfile_bank_map #(.ADDR_WIDTH(ADDR_WIDTH)) u_map_wr1 (
        .mode(mode), .addr(wr1_addr), .phys_idx(w1_idx), .is_pc(w1_pc)
    );

    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd_map
        regfile_bank_map #(.ADDR_WIDTH(ADDR_WIDTH)) u_map_rd (
            .mode(mode),
            .addr(read_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .phys_idx(rd_idx[g]),
            .is_pc(rd_pc[g])
        );
    end

    assign w0_reg = wr0_we && !w0_pc;
    assign w1_reg = wr1_we && !w1_pc;

    // Next PC: wr0 to r15 beats wr1 to r15, which beats the dedicated port.
    always_comb begin
        pc_next = pc_out;
        if (wr0_we && w0_pc)      pc_next = wr0_data;
        else if (wr1_we && w1_pc) pc_next = wr1_data;
        else if (pc_we)           pc_next = pc_in;
    end

    // Write-first read values; wr0 is applied last so it wins a collision.
    always_comb begin
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            rd_next[k] = regs[rd_idx[k]];
            if (w1_reg && w1_idx == rd_idx[k]) rd_next[k] = wr1_data;
            if (w0_reg && w0_idx == rd_idx[k]) rd_next[k] = wr0_data;
            if (rd_pc[k])                      rd_next[k] = pc_next;
        end
    end

    // Current-mode SPSR with write-first bypass; user/system has none.
    always_comb begin
        spsr_next = '0;
        if (bank != BANK_USR) begin
            spsr_next = spsr_we ? spsr_in : spsr_regs[spsr_idx];
        end
    end

    // General-purpose register array, wr0 taking priority on a shared target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset because every GPR must read 0 after reset; this forces flops, not RAM.
            for (int i = 0; i < NUM_PHYS; i++) regs[i] <= '0;
        end else begin
            if (w0_reg) regs[w0_idx] <= wr0_data;
            if (w1_reg && !(w0_reg && w0_idx == w1_idx)) regs[w1_idx] <= wr1_data;
        end
    end

    // Banked SPSR storage, written only from an exception mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPSR; i++) spsr_regs[i] <= '0;
        end else if (spsr_we && bank != BANK_USR) begin
            spsr_regs[spsr_idx] <= spsr_in;
        end
    end

    // Registered outputs: PC, CPSR, SPSR view and read ports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out    <= PC_RESET;
            cpsr_out  <= CPSR_RESET;
            spsr_out  <= '0;
            read_data <= '0;
        end else begin
            pc_out   <= pc_next;
            spsr_out <= spsr_next;
            if (cpsr_we) cpsr_out <= cpsr_in;
            for (int k = 0; k < NUM_READ_PORTS; k++) begin
                read_data[k*WORD_SIZE +: WORD_SIZE] <= rd_next[k];
            end
        end
    end

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Directed self-checking bench for arm_banked_regfile. Expected values are
// hand-derived from the architectural behaviour; FIQ r8 expectations follow
// REGFILE_FIQ_BANK_EN.
module tb_arm_banked_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] read_addr;
    logic [95:0] read_data;
    logic        wr0_we, wr1_we, pc_we, cpsr_we, spsr_we;
    logic [3:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data, pc_in, cpsr_in, spsr_in;
    logic [31:0] pc_out, cpsr_out, spsr_out;

    int n_pass  = 0;
    int n_total = 0;

    arm_banked_regfile dut (
        .clk(clk), .reset(reset),
        .read_addr(read_addr), .read_data(read_data),
        .wr0_we(wr0_we), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_we(wr1_we), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pc_we(pc_we), .pc_in(pc_in), .pc_out(pc_out),
        .cpsr_we(cpsr_we), .cpsr_in(cpsr_in), .cpsr_out(cpsr_out),
        .spsr_we(spsr_we), .spsr_in(spsr_in), .spsr_out(spsr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        wr0_we = 1'b0; wr1_we = 1'b0; pc_we = 1'b0; cpsr_we = 1'b0; spsr_we = 1'b0;
    endtask

    task automatic set_cpsr(input logic [31:0] v);
        cpsr_we = 1'b1; cpsr_in = v;
    endtask

    task automatic do_wr0(input logic [3:0] a, input logic [31:0] d);
        wr0_we = 1'b1; wr0_addr = a; wr0_data = d;
    endtask

    task automatic do_wr1(input logic [3:0] a, input logic [31:0] d);
        wr1_we = 1'b1; wr1_addr = a; wr1_data = d;
    endtask

    function automatic logic [31:0] slice(input int k);
        return read_data[k*32 +: 32];
    endfunction

    initial begin
        reset = 1'b0;
        read_addr = '0;
        wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
        pc_in = '0; cpsr_in = '0; spsr_in = '0;
        clear_ctl();
        step();
        step();
        check("rst_read_data_lo", read_data[31:0], 32'h0);
        check("rst_read_data_hi", read_data[95:64], 32'h0);
        check("rst_cpsr", cpsr_out, 32'h0000_00D3);
        check("rst_pc", pc_out, 32'h0);
        check("rst_spsr", spsr_out, 32'h0);
        reset = 1'b1;

        // 1: every r0-r14 reads zero after reset
        for (int g = 0; g < 5; g++) begin
            read_addr = {4'(3*g+2), 4'(3*g+1), 4'(3*g)};
            step();
            for (int k = 0; k < 3; k++) check($sformatf("rst_r%0d", 3*g+k), slice(k), 32'h0);
        end

        // 2: r13 banked between SVC and USR
        do_wr0(4'd13, 32'h100);
        step(); clear_ctl();
        set_cpsr(32'h10);
        step(); clear_ctl();
        check("cpsr_usr", cpsr_out, 32'h10);
        do_wr0(4'd13, 32'h200);
        step(); clear_ctl();
        read_addr = {4'd0, 4'd0, 4'd13};
        step();
        check("usr_r13", slice(0), 32'h200);
        set_cpsr(32'hD3);
        step(); clear_ctl();
        step();
        check("svc_r13", slice(0), 32'h100);

        // 3: FIQ r8 banking
        set_cpsr(32'hD1);
        step(); clear_ctl();
        do_wr0(4'd8, 32'hAA);
        step(); clear_ctl();
        read_addr = {4'd0, 4'd0, 4'd8};
        step();
        check("fiq_r8", slice(0), 32'hAA);
        read_addr = {4'd0, 4'd0, 4'd13};
        step();
        check("fiq_r13", slice(0), 32'h0);
        set_cpsr(32'h10);
        step(); clear_ctl();
        read_addr = {4'd0, 4'd0, 4'd8};
        step();
`ifdef REGFILE_FIQ_BANK_EN
        check("usr_r8", slice(0), 32'h0);
`else
        check("usr_r8", slice(0), 32'hAA);
`endif

        // 4: collision (wr0 wins) and write-first bypass
        read_addr = {4'd3, 4'd4, 4'd0};
        do_wr0(4'd3, 32'd5);
        do_wr1(4'd3, 32'd9);
        step(); clear_ctl();
        check("collide_bypass", slice(2), 32'd5);
        do_wr1(4'd4, 32'h44);
        step(); clear_ctl();
        check("wr1_bypass", slice(1), 32'h44);
        check("collide_stored", slice(2), 32'd5);

        // 5: CPSR write uses old mode for the same-edge register write
        set_cpsr(32'hD3);
        step(); clear_ctl();
        set_cpsr(32'hD2);
        do_wr0(4'd14, 32'h77);
        step(); clear_ctl();
        read_addr = {4'd0, 4'd0, 4'd14};
        step();
        check("irq_r14", slice(0), 32'h0);
        set_cpsr(32'hD3);
        step(); clear_ctl();
        step();
        check("svc_r14", slice(0), 32'h77);

        // SPSR: bypass, old-mode view on switch, ignored in USR
        spsr_we = 1'b1; spsr_in = 32'hABCD;
        step(); clear_ctl();
        check("spsr_bypass", spsr_out, 32'hABCD);
        set_cpsr(32'h10);
        step(); clear_ctl();
        check("spsr_old_mode", spsr_out, 32'hABCD);
        step();
        check("spsr_usr_zero", spsr_out, 32'h0);
        spsr_we = 1'b1; spsr_in = 32'h1234;
        step(); clear_ctl();
        check("spsr_usr_ignored", spsr_out, 32'h0);
        set_cpsr(32'hD3);
        step(); clear_ctl();
        step();
        check("spsr_svc_kept", spsr_out, 32'hABCD);

        // 6: PC write precedence and r15 reads
        pc_we = 1'b1; pc_in = 32'h40;
        do_wr1(4'd15, 32'h80);
        step(); clear_ctl();
        check("pc_wr1_over_pcwe", pc_out, 32'h80);
        read_addr = {4'd0, 4'd0, 4'd15};
        step();
        check("r15_read", slice(0), 32'h80);
        do_wr0(4'd15, 32'h10);
        do_wr1(4'd15, 32'h20);
        step(); clear_ctl();
        check("pc_wr0_over_wr1", pc_out, 32'h10);
        pc_we = 1'b1; pc_in = 32'h40;
        step(); clear_ctl();
        check("pc_we_alone", pc_out, 32'h40);

        // Asynchronous reset mid-cycle clears everything at once
        read_addr = {4'd3, 4'd0, 4'd15};
        step();
        #2 reset = 1'b0;
        #1;
        check("arst_pc", pc_out, 32'h0);
        check("arst_cpsr", cpsr_out, 32'h0000_00D3);
        check("arst_rd0", slice(0), 32'h0);
        check("arst_spsr", spsr_out, 32'h0);
        reset = 1'b1;
        step();
        check("post_rst_r3", slice(2), 32'h0);
        check("post_rst_spsr", spsr_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arm_banked_regfile.md
# arm_banked_regfile

Parametrised successor to the ARM core's `register_file`. It provides a configurable number of registered read ports and two write ports. It implements ARM processor-mode banking of r8–r14 and one SPSR per exception mode, with the mode taken from the stored CPSR. It sits between decode and the execute datapath, and replaces the flat 16-entry file.

## Interface
- `WORD_SIZE`, 32, register width
- `ADDR_WIDTH`, 4, architectural register address width (r0–r15)
- `NUM_READ_PORTS`, 3, number of read ports (rn, rm, rs)
- `PC_RESET`, 0, PC value loaded at reset
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `read_addr`  in  NUM_READ_PORTS×ADDR_WIDTH  packed read addresses; port k occupies slice k
- `read_data`  out  NUM_READ_PORTS×WORD_SIZE  packed registered read data
- `wr0_we`, `wr1_we`  in  1 each  write enables
- `wr0_addr`, `wr1_addr`  in  ADDR_WIDTH each  write addresses
- `wr0_data`, `wr1_data`  in  WORD_SIZE each  write data
- `pc_we`  in  1  PC write enable
- `pc_in`  in  WORD_SIZE  PC write data
- `pc_out`  out  WORD_SIZE  current PC
- `cpsr_we`  in  1  CPSR write enable
- `cpsr_in`  in  WORD_SIZE  CPSR write data
- `cpsr_out`  out  WORD_SIZE  current CPSR
- `spsr_we`  in  1  SPSR write enable (current mode)
- `spsr_in`  in  WORD_SIZE  SPSR write data
- `spsr_out`  out  WORD_SIZE  registered SPSR of the current mode

## Operation
- **Mode source:** `cpsr_out[4:0]`.
  - USR=10000, FIQ=10001, IRQ=10010, SVC=10011, ABT=10111, UND=11011, SYS=11111.
  - Any other encoding is treated as USR for banking.
- **Banking:**
  - r13 and r14 are banked per FIQ, IRQ, SVC, ABT and UND.
  - r8–r12 are additionally banked for FIQ (see Configuration).
  - USR and SYS share the user bank.
  - Physical storage: 15 user entries, 7 FIQ entries, 8 other-mode entries (r13/r14 × 4 modes), 5 SPSRs.
- **r15:**
  - Reads return `pc_out`.
  - A `wrN` write to r15 updates the PC.
  - Precedence when several sources write the PC in one cycle: `wr0` > `wr1` > `pc_we`.
- **Write collision:** if `wr0` and `wr1` target the same architectural register in one cycle, `wr0` wins.
- **Mode used for an access:** all writes and read address resolution in a cycle use the mode in effect *before* that edge. A simultaneous `cpsr_we` affects only the next cycle.
- **SPSR:**
  - In USR/SYS, `spsr_out` reads 0 and `spsr_we` is ignored.
  - Otherwise `spsr_we` writes the current mode's SPSR.
- **Reset values:**
  - All GPRs and SPSRs = 0.
  - `pc_out` = PC_RESET.
  - `cpsr_out` = 32'h0000_00D3 (SVC, IRQ/FIQ masked).
  - `read_data` = 0; `spsr_out` = 0.

## Timing
- Read latency is 1 cycle. `read_data` slice k updates only on the rising edge, from `read_addr` slice k sampled at that edge.
- **Write-first bypass:** if a write resolves to the same physical register at the same edge, `read_data` shows the new value.
- Outputs change only on the clock edge or on asynchronous reset assertion. Address changes mid-cycle must not glitch `read_data`.
- `spsr_out` is registered with the same bypass rule for `spsr_we` and for the mode before the edge.
- `pc_out` and `cpsr_out` reflect writes one edge after the enable.
- Reset asserted mid-operation clears everything immediately. The first write accepted is at the first rising edge after deassertion.

## Configuration
- `REGFILE_FIQ_BANK_EN`
  - **Defined:** r8–r12 are banked for FIQ (7 FIQ entries).
  - **Undefined:** FIQ banks only r13/r14 (like IRQ), FIQ r8–r12 alias the user bank, and the 5 FIQ-only entries are not instantiated.

## Structure
- Shared package `armcpu_pkg` holds:
  - mode encodings (`MODE_USR` … `MODE_SYS`)
  - bank index enum
  - physical register count constants
  - `CPSR_RESET = 32'h0000_00D3`
- Sub-module `regfile_bank_map`: combinational (mode, arch addr) → (physical index, is_pc). One instance per read port and per write port.

## Test plan
1. **Reset value:** reset low, then release; read r0–r14 → all 0, `cpsr_out` = 0xD3, `pc_out` = 0.
2. **Banked r13:** in SVC, write r13 = 0x100; write CPSR mode = USR; write r13 = 0x200; read r13 → 0x200; return to SVC, read r13 → 0x100.
3. **FIQ banking:** in FIQ, write r8 = 0xAA; in USR, read r8 → 0. With `REGFILE_FIQ_BANK_EN` undefined, USR read r8 → 0xAA.
4. **Write collision and bypass:** same edge: `wr0` r3 = 5, `wr1` r3 = 9, read r3 on port 2 → `read_data` slice 2 = 5 after that edge.
5. **Mode change in same cycle:** `cpsr_we` to IRQ together with `wr0` r14 = 0x77 → SVC r14 = 0x77, IRQ r14 unchanged at 0.
6. **PC precedence:** `pc_we` with `pc_in` = 0x40 and `wr1` r15 = 0x80 → `pc_out` = 0x80. Reading r15 then returns 0x80.
